// File: rtl/drop_sequencer_pkg.sv
// drop_sequencer_pkg: FSM encoding and TUSER port-field constants shared by the drop_sequencer slice.
package drop_sequencer_pkg;
  typedef enum logic [1:0] {
    WAIT_VERDICT = 2'd0,
    FORWARD      = 2'd1,
    DISCARD      = 2'd2
  } state_t;
  localparam int DST_PORT_POS_DEF = 24;
  localparam int PORT_W = 8;
endpackage

// File: rtl/drop_sequencer_if.sv
// drop_sequencer_if: AXI4-Stream bundle with master/slave views.
interface drop_sequencer_if #(
  parameter int DW = 256,
  parameter int UW = 128
) ();
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic [UW-1:0] tuser;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/drop_sequencer_skid.sv
// drop_sequencer_skid: 2-entry register slice; in_ready comes only from a flop, never from out_ready.
module drop_sequencer_skid #(
  parameter int W = 417
) (
  input  logic         AXI_ACLK,
  input  logic         AXI_RESET,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic skid_valid;
  logic [W-1:0] skid_data;
  assign in_ready = !skid_valid;
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_valid <= 1'b0;
      skid_data <= '0;
    end else if (out_ready || !out_valid) begin
      out_valid <= skid_valid || in_valid;
      out_data <= skid_valid ? skid_data : in_valid ? in_data : out_data;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data <= in_data;
    end
endmodule

// File: rtl/drop_sequencer.sv
// drop_sequencer: forwards (with TUSER port rewrite) or discards each packet per in-order verdict.
// Statistics counters are built only when DROP_SEQUENCER_STATS_EN is defined.
module drop_sequencer
  import drop_sequencer_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS = DST_PORT_POS_DEF
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_RESET,
  drop_sequencer_if.slave               s_axis,
  drop_sequencer_if.master              m_axis,
  input  logic                          VERDICT_VALID,
  input  logic                          VERDICT_DROP,
  input  logic [PORT_W-1:0]             VERDICT_PORT,
  output logic                          VERDICT_READY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] stats_reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0] fwd_pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] drop_pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] drop_beat_count
);
  localparam int CW = C_S_AXI_DATA_WIDTH;
  localparam int SW = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + C_S_AXIS_DATA_WIDTH;
  localparam int MW = 1 + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH / 8 + C_M_AXIS_DATA_WIDTH;
  state_t state;
  logic first;
  logic [PORT_W-1:0] port;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
  logic skid_ready;
  logic beat;
  logic [MW-1:0] m_data;
  assign VERDICT_READY = state == WAIT_VERDICT;
  assign s_axis.tready = state == DISCARD || (state == FORWARD && skid_ready);
  assign beat = s_axis.tvalid && s_axis.tready;
  always_comb begin
    tuser = s_axis.tuser;
    if (first) tuser[DST_PORT_POS +: PORT_W] = port;
  end
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) begin
      state <= WAIT_VERDICT;
      first <= 1'b0;
      port <= '0;
    end else if (state == WAIT_VERDICT) begin
      if (VERDICT_VALID) begin
        state <= VERDICT_DROP ? DISCARD : FORWARD;
        port <= VERDICT_PORT;
        first <= 1'b1;
      end
    end else if (beat) begin
      first <= 1'b0;
      if (s_axis.tlast) state <= WAIT_VERDICT;
    end
  drop_sequencer_skid #(.W(SW)) u_skid (
    .AXI_ACLK  (AXI_ACLK),
    .AXI_RESET (AXI_RESET),
    .in_data   ({s_axis.tlast, tuser, s_axis.tstrb, s_axis.tdata}),
    .in_valid  (s_axis.tvalid && state == FORWARD),
    .in_ready  (skid_ready),
    .out_data  (m_data),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready)
  );
  assign {m_axis.tlast, m_axis.tuser, m_axis.tstrb, m_axis.tdata} = m_data;
`ifdef DROP_SEQUENCER_STATS_EN
  logic [CW-1:0] fwd_q, dpk_q, dbt_q;
  logic clr;
  assign clr = stats_reset == CW'(1);
  // clear has priority over any increment landing in the same cycle
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) begin
      fwd_q <= '0;
      dpk_q <= '0;
      dbt_q <= '0;
    end else if (clr) begin
      fwd_q <= '0;
      dpk_q <= '0;
      dbt_q <= '0;
    end else begin
      if (beat && s_axis.tlast && state == FORWARD) fwd_q <= fwd_q + CW'(1);
      if (beat && state == DISCARD) begin
        dbt_q <= dbt_q + CW'(1);
        if (s_axis.tlast) dpk_q <= dpk_q + CW'(1);
      end
    end
  assign fwd_pkt_count = clr ? '0 : fwd_q;
  assign drop_pkt_count = clr ? '0 : dpk_q;
  assign drop_beat_count = clr ? '0 : dbt_q;
`else
  logic unused_stats;
  assign unused_stats = ^stats_reset;
  assign fwd_pkt_count = '0;
  assign drop_pkt_count = '0;
  assign drop_beat_count = '0;
`endif
endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: directed scoreboard bench for drop_sequencer (counters expected 0 unless DROP_SEQUENCER_STATS_EN).
module tb_drop_sequencer;
`ifdef DROP_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v_valid = 1'b0, v_drop = 1'b0, v_ready;
  logic [7:0] v_port = '0;
  logic [31:0] stats_reset = '0;
  logic [31:0] fwd_cnt, dpk_cnt, dbt_cnt;
  int tests = 0, fails = 0;
  int exp_fwd = 0, exp_dpk = 0, exp_dbt = 0;
  logic [416:0] q[$];
  logic [416:0] prev = '0;
  logic stall = 1'b0;
  drop_sequencer_if #(.DW(256), .UW(128)) s_if ();
  drop_sequencer_if #(.DW(256), .UW(128)) m_if ();
  drop_sequencer dut (
    .AXI_ACLK        (clk),
    .AXI_RESET       (rst),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .VERDICT_VALID   (v_valid),
    .VERDICT_DROP    (v_drop),
    .VERDICT_PORT    (v_port),
    .VERDICT_READY   (v_ready),
    .stats_reset     (stats_reset),
    .fwd_pkt_count   (fwd_cnt),
    .drop_pkt_count  (dpk_cnt),
    .drop_beat_count (dbt_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_counts(input string tag);
    check({tag, "_fwd"}, fwd_cnt, STATS ? exp_fwd : 0);
    check({tag, "_dpk"}, dpk_cnt, STATS ? exp_dpk : 0);
    check({tag, "_dbt"}, dbt_cnt, STATS ? exp_dbt : 0);
  endtask
  // output monitor: pops the scoreboard on every M_AXIS handshake and checks hold-while-stalled
  always @(negedge clk) begin
    if (rst) stall = 1'b0;
    else begin
      if (stall) check("axis_hold", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata}, {1'b1, prev});
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) check("unexpected_beat", 1'b1, 1'b0);
        else check("beat", {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata}, q.pop_front());
      end
      stall = m_if.tvalid && !m_if.tready;
      prev = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
    end
  end
  task automatic rand_beat(input bit last);
    for (int k = 0; k < 8; k++) s_if.tdata[k*32 +: 32] = $urandom();
    for (int k = 0; k < 4; k++) s_if.tuser[k*32 +: 32] = $urandom();
    s_if.tuser[31:24] = 8'h01;
    s_if.tstrb = '1;
    s_if.tlast = last;
    s_if.tvalid = 1'b1;
  endtask
  task automatic verdict(input bit d, input logic [7:0] p);
    bit acc;
    int n = 0;
    v_valid = 1'b1; v_drop = d; v_port = p;
    do begin
      @(negedge clk); acc = v_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    v_valid = 1'b0;
    check("verdict_hs", acc, 1'b1);
    check("tready_after_verdict", s_if.tready, 1'b1);
    check("vready_after_verdict", v_ready, 1'b0);
  endtask
  task automatic send_pkt(input int n, input bit drop, input logic [7:0] port, input bit clr_last);
    logic [416:0] b;
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      rand_beat(i == n - 1);
      if (clr_last && i == n - 1) stats_reset = 32'd1;
      if (!drop) begin
        b = {s_if.tlast, s_if.tuser, s_if.tstrb, s_if.tdata};
        if (i == 0) b[312 +: 8] = port;
        q.push_back(b);
      end
      tries = 0;
      do begin
        @(negedge clk); acc = s_if.tready;
        @(posedge clk); #1; tries++;
      end while (!acc && tries < 100);
      check("in_accept", acc, 1'b1);
      if (drop) begin
        check("discard_ready", tries, 1);
        exp_dbt++;
      end
    end
    s_if.tvalid = 1'b0;
    if (drop) exp_dpk++; else exp_fwd++;
    if (clr_last) begin exp_fwd = 0; exp_dpk = 0; exp_dbt = 0; end
    check("eop_vready", v_ready, 1'b1);
    check("eop_tready", s_if.tready, 1'b0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tstrb = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", m_if.tvalid, 1'b0);
    check("rst_mpayload", {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata}, '0);
    check("rst_stready", s_if.tready, 1'b0);
    check("rst_vready", v_ready, 1'b1);
    check_counts("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    // forward with port rewrite
    verdict(1'b0, 8'h04);
    send_pkt(3, 1'b0, 8'h04, 1'b0);
    drain();
    check_counts("fwd");
    // discard
    verdict(1'b1, 8'h02);
    send_pkt(4, 1'b1, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("discard_no_output", q.size(), 0);
    check_counts("discard");
    // alternating single-beat packets
    verdict(1'b0, 8'h02); send_pkt(1, 1'b0, 8'h02, 1'b0);
    verdict(1'b1, 8'h40); send_pkt(1, 1'b1, 8'h00, 1'b0);
    verdict(1'b0, 8'h80); send_pkt(1, 1'b0, 8'h80, 1'b0);
    verdict(1'b1, 8'h01); send_pkt(1, 1'b1, 8'h00, 1'b0);
    drain();
    check_counts("alt");
    // backpressure mid-packet
    verdict(1'b0, 8'h08);
    fork
      send_pkt(6, 1'b0, 8'h08, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stready_low", s_if.tready, 1'b0);
        check("bp_mvalid_held", m_if.tvalid, 1'b1);
        repeat (2) @(posedge clk);
        #1 m_if.tready = 1'b1;
      end
    join
    drain();
    check_counts("bp");
    // clear versus same-cycle increment
    verdict(1'b1, 8'h00);
    send_pkt(2, 1'b1, 8'h00, 1'b1);
    check("clr_dpk_zero", dpk_cnt, 32'd0);
    stats_reset = 32'd0;
    @(posedge clk); #1;
    check_counts("clr");
    verdict(1'b1, 8'h00);
    send_pkt(1, 1'b1, 8'h00, 1'b0);
    check_counts("after_clr");
    // async reset mid-forward
    verdict(1'b0, 8'h10);
    rand_beat(1'b0);
    q.push_back({s_if.tlast, s_if.tuser[127:32], 8'h10, s_if.tuser[23:0], s_if.tstrb, s_if.tdata});
    @(posedge clk); #1;
    rand_beat(1'b0);
    @(posedge clk); #1;
    rand_beat(1'b0);
    #2 rst = 1'b1;
    #1;
    exp_fwd = 0; exp_dpk = 0; exp_dbt = 0;
    check("arst_mvalid", m_if.tvalid, 1'b0);
    check("arst_vready", v_ready, 1'b1);
    check("arst_stready", s_if.tready, 1'b0);
    check("arst_queue", q.size(), 0);
    check_counts("arst");
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    verdict(1'b0, 8'h20);
    send_pkt(2, 1'b0, 8'h20, 1'b0);
    drain();
    check_counts("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
